// File: rtl/fpu_pkg.sv
// Shared FP32 constants, state and classification types for the float-to-fixed converter.
package fpu_pkg;

   localparam int SIGN_W   = 1;
   localparam int EXP_W    = 8;
   localparam int FP_FRAC_W = 23;
   localparam int MANT_W   = FP_FRAC_W + 1;
   localparam int EXP_BIAS = 127;

   localparam logic [EXP_W-1:0] EXP_ZERO = 8'd0;
   localparam logic [EXP_W-1:0] EXP_MAX  = 8'd255;

   localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_NEG = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      CLS_NORMAL,
      CLS_ZERO,
      CLS_NAN,
      CLS_SAT,
      CLS_UNDER
   } fp_class_t;

endpackage

// File: rtl/fp_to_fixed_if.sv
// Operand/result handshake bundle; out_inexact exists only with FP_TO_FIXED_INEXACT_EN.
interface fp_to_fixed_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_ovf;
   logic        out_nan;
`ifdef FP_TO_FIXED_INEXACT_EN
   logic        out_inexact;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
   );
`else
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_nan
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_nan
   );
`endif

endinterface

// File: rtl/fp_unpack.sv
// Combinational FP32 field extraction, shift computation and special-case classification.
module fp_unpack
   import fpu_pkg::*;
#(
   parameter int FRAC_W = 16
) (
   input  logic [31:0]       data,
   output logic              sign,
   output logic [MANT_W-1:0] mant,
   output logic signed [9:0] k,
   output fp_class_t         cls
);

   localparam int K_OFFSET = EXP_BIAS + FP_FRAC_W;

   logic [EXP_W-1:0]     exp_f;
   logic [FP_FRAC_W-1:0] frac_f;

   assign sign   = data[31];
   assign exp_f  = data[30:23];
   assign frac_f = data[22:0];
   assign mant   = {1'b1, frac_f};

   // k = (e - bias) - 23 + FRAC_W, evaluated in 10-bit signed
   assign k = $signed({2'b00, exp_f}) - $signed(10'(K_OFFSET)) + $signed(10'(FRAC_W));

   always_comb begin
      cls = CLS_NORMAL;
      if (exp_f == EXP_ZERO) begin
         cls = CLS_ZERO;
      end else if (exp_f == EXP_MAX) begin
         cls = (frac_f != '0) ? CLS_NAN : CLS_SAT;
      end else if (k >= 10'sd8) begin
         cls = CLS_SAT;
      end else if (k <= -10'sd24) begin
         cls = CLS_UNDER;
      end
   end

endmodule

// File: rtl/fp_to_fixed.sv
// Serial FP32 -> signed 32-bit fixed-point converter (one shift per cycle).
// Optional out_inexact sticky flag under macro FP_TO_FIXED_INEXACT_EN.
module fp_to_fixed
   import fpu_pkg::*;
#(
   parameter int FRAC_W = 16
) (
   input logic          clk,
   input logic          rst,
   fp_to_fixed_if.slave bus
);

   state_t state, state_nxt;

   logic              u_sign;
   logic [MANT_W-1:0] u_mant;
   logic signed [9:0] u_k;
   fp_class_t         u_cls;

   logic        accept;
   logic [9:0]  k_abs;
   logic        sign_q;
   logic        left_q;
   logic [9:0]  count_q;
   logic [31:0] mag_q;
   logic [31:0] data_q;
   logic        ovf_q;
   logic        nan_q;

   fp_unpack #(.FRAC_W(FRAC_W)) u_unpack (
      .data (bus.in_data),
      .sign (u_sign),
      .mant (u_mant),
      .k    (u_k),
      .cls  (u_cls)
   );

   assign accept = bus.in_valid && (state == IDLE);
   assign k_abs  = u_k[9] ? (~u_k + 10'd1) : u_k;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_data  = data_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_nan   = nan_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = (u_cls == CLS_NORMAL) ? SHIFT : DONE;
         SHIFT:   if (count_q == '0) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FP_TO_FIXED_INEXACT_EN
   logic inexact_q;
   assign bus.out_inexact = inexact_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inexact_q <= 1'b0;
      end else if (accept) begin
         inexact_q <= (u_cls == CLS_UNDER);
      end else if (state == SHIFT && count_q != '0 && !left_q) begin
         inexact_q <= inexact_q | mag_q[0];
      end
   end
`endif

   // Direct cases resolve their result at acceptance; shifted cases at SHIFT exit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_q  <= 1'b0;
         left_q  <= 1'b0;
         count_q <= '0;
         mag_q   <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         nan_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  sign_q  <= u_sign;
                  left_q  <= ~u_k[9];
                  count_q <= k_abs;
                  mag_q   <= {8'h00, u_mant};
                  unique case (u_cls)
                     CLS_NAN: begin
                        data_q <= '0;
                        ovf_q  <= 1'b0;
                        nan_q  <= 1'b1;
                     end
                     CLS_SAT: begin
                        data_q <= u_sign ? SAT_NEG : SAT_POS;
                        ovf_q  <= 1'b1;
                        nan_q  <= 1'b0;
                     end
                     CLS_ZERO, CLS_UNDER: begin
                        data_q <= '0;
                        ovf_q  <= 1'b0;
                        nan_q  <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            SHIFT: begin
               if (count_q != '0) begin
                  count_q <= count_q - 10'd1;
                  mag_q   <= left_q ? (mag_q << 1) : (mag_q >> 1);
               end else begin
                  data_q <= sign_q ? -mag_q : mag_q;
                  ovf_q  <= 1'b0;
                  nan_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Self-checking bench for fp_to_fixed: directed cases, reset abort, randomized traffic vs. a value-level model.
module tb_fp_to_fixed;

   localparam int FRAC_W = 16;

   typedef struct {
      logic [31:0] x;
      logic [31:0] d;
      bit          ovf;
      bit          nan;
      bit          inex;
      int          lat;
      int          hold;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   fp_to_fixed_if bus ();

   fp_to_fixed #(.FRAC_W(FRAC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Exact real value M * 2^(e-150) scaled by 2^FRAC_W, truncated toward zero, saturated at 32 bits
   function automatic vec_t model(input logic [31:0] x, input int hold);
      vec_t   v;
      longint m, mag;
      int     e, k, sh;
      bit     big, lost;
      v.x = x; v.hold = hold; v.d = '0;
      v.ovf = 0; v.nan = 0; v.inex = 0; v.lat = 1;
      e = int'(x[30:23]);
      m = longint'({1'b1, x[22:0]});
      k = e - 150 + FRAC_W;
      if (e == 255) begin
         if (x[22:0] != 0) v.nan = 1;
         else v.ovf = 1;
      end else if (e != 0) begin
         big = 0; lost = 0; mag = 0;
         if (k >= 0) begin
            if (k > 31) big = 1;
            else mag = m <<< k;
         end else begin
            sh = -k;
            if (sh >= 32) begin
               mag = 0; lost = 1;
            end else begin
               mag  = m >>> sh;
               lost = ((m & ((64'sd1 <<< sh) - 1)) != 0);
            end
         end
         if (big || mag >= 64'sd2147483648) begin
            v.ovf = 1;
         end else begin
            v.inex = lost;
            v.d    = x[31] ? 32'(-mag) : 32'(mag);
            if (mag != 0) v.lat = ((k < 0) ? -k : k) + 2;
         end
      end
      if (v.ovf) v.d = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return v;
   endfunction

   task automatic run_op(input vec_t v, input bit keep_valid);
      int w;
      int lat;
      bus.in_valid  = 1'b1;
      bus.in_data   = v.x;
      bus.out_ready = 1'b0;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (keep_valid) bus.in_data = $urandom;
      else bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(v.lat));
      check("data", bus.out_data, v.d);
      check("ovf", 32'(bus.out_ovf), 32'(v.ovf));
      check("nan", 32'(bus.out_nan), 32'(v.nan));
`ifdef FP_TO_FIXED_INEXACT_EN
      check("inexact", 32'(bus.out_inexact), 32'(v.inex));
`endif
      check("busy_ready", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_data", bus.out_data, v.d);
         check("hold_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("post_valid", 32'(bus.out_valid), 32'd0);
      check("post_ready", 32'(bus.in_ready), 32'd1);
   endtask

   vec_t dirs[7] = '{
      '{32'h3F80_0000, 32'h0001_0000, 0, 0, 0, 9, 0},
      '{32'hC020_0000, 32'hFFFD_8000, 0, 0, 0, 8, 5},
      '{32'h4700_0000, 32'h7FFF_FFFF, 1, 0, 0, 1, 1},
      '{32'hFF80_0000, 32'h8000_0000, 1, 0, 0, 1, 0},
      '{32'h7FC0_0000, 32'h0000_0000, 0, 1, 0, 1, 0},
      '{32'h3380_0000, 32'h0000_0000, 0, 0, 1, 1, 0},
      '{32'h8000_0000, 32'h0000_0000, 0, 0, 0, 1, 0}
   };

   initial begin
      bit          seen;
      logic [31:0] x;
      logic [7:0]  e;
      vec_t        v;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #12;
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", bus.out_data, 32'd0);
      check("rst_ovf", 32'(bus.out_ovf), 32'd0);
      check("rst_nan", 32'(bus.out_nan), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (dirs[i]) run_op(dirs[i], 1'b0);

      // Reset while a conversion is in flight
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3F80_0000;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_rst_valid", 32'(bus.out_valid), 32'd0);
      check("abort_rst_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_ready", 32'(bus.in_ready), 32'd1);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1;
      end
      check("abort_no_result", 32'(seen), 32'd0);
      run_op('{32'h4000_0000, 32'h0002_0000, 0, 0, 0, 8, 0}, 1'b0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0:       e = 8'd0;
            1:       e = 8'd255;
            default: e = 8'($urandom_range(100, 160));
         endcase
         x = {1'($urandom), e, 23'($urandom)};
         v = model(x, int'($urandom_range(0, 3)));
         run_op(v, 1'($urandom));
      end

      // Back-to-back traffic with in_valid never dropped
      for (int n = 0; n < 6; n++) begin
         x = {1'($urandom), 8'($urandom_range(120, 150)), 23'($urandom)};
         run_op(model(x, 0), 1'b1);
      end
      bus.in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/fp_to_fixed.md
FP_TO_FIXED -- requirements
Module: fp_to_fixed

Interface
REQ-001 SHALL have parameter FRAC_W, default 16: number of fraction bits in the signed 32-bit fixed-point output; legal range 0..30.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1: the block accepts an operand this cycle.
REQ-006 SHALL have port in_data, input, 32: IEEE-754 single-precision operand.
REQ-007 SHALL have port out_valid, output, 1: out_data and the flags are valid.
REQ-008 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-009 SHALL have port out_data, output, 32: two's-complement fixed-point result with FRAC_W fraction bits.
REQ-010 SHALL have port out_ovf, output, 1: result saturated (magnitude overflow or infinity).
REQ-011 SHALL have port out_nan, output, 1: operand was NaN.

Function
REQ-012 SHALL use the states IDLE, SHIFT and DONE; in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-013 SHALL accept an operand on an edge where in_valid and in_ready are both 1, and SHALL latch sign s, exponent e, fraction f, mantissa M = {1,f} (24 bits) and shift k = (e-127) - 23 + FRAC_W (signed, 10 bits).
REQ-014 SHALL go from IDLE directly to DONE (latency 1) for these operands:
- e=0 (zero/denormal flushed) -> 0, flags clear.
- e=255, f≠0 -> 0, out_nan=1.
- e=255, f=0, or k≥8 -> saturate to 0x7FFFFFFF if s=0, 0x80000000 if s=1, out_ovf=1.
- k≤-24 -> 0.
REQ-015 SHALL otherwise go to SHIFT with count=|k| and direction = left if k≥0, right if k<0.
REQ-016 SHALL, in SHIFT, shift the magnitude register one bit per cycle and decrement count while count≠0; when count=0 it SHALL go to DONE, giving latency |k|+2 edges from acceptance to out_valid.
REQ-017 SHALL truncate right shifts toward zero in magnitude.
REQ-018 SHALL apply the sign on entry to DONE: out_data = s ? -mag : mag.
REQ-019 SHALL hold out_data and the flags stable in DONE until out_valid && out_ready, then go to IDLE; a new operand SHALL NOT be accepted on that same edge.
REQ-020 SHALL ignore in_data and in_valid outside IDLE.
REQ-021 SHALL treat -0.0 as 0x00000000.

Reset
REQ-022 SHALL, while rst=1, force state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, out_nan=0, count=0, and clear the magnitude register.
REQ-023 SHALL abandon any operation in progress (SHIFT or DONE) on rst assertion, with no result delivered.

Configuration
REQ-024 SHALL, when macro FP_TO_FIXED_INEXACT_EN is defined, add output port out_inexact (1 bit), reset 0.
- Set to the OR of all 1-bits shifted out during right shifts, and 1 for the k≤-24 case with e≠0.
- Cleared at acceptance.
REQ-025 SHALL, when FP_TO_FIXED_INEXACT_EN is undefined, have neither the port nor its logic.

Structure
REQ-026 SHALL place the following in shared package fpu_pkg:
- FP32 field widths (1/8/23) and EXP_BIAS=127.
- Special exponent constants 0 and 255.
- The state enum (IDLE/SHIFT/DONE).
- Saturation constants.
REQ-027 SHALL implement field extraction and special-case classification in one combinational sub-module, fp_unpack; the FSM, shifter and sign stage SHALL stay in fp_to_fixed.

Verification (FRAC_W=16)
REQ-028 SHALL cover: 0x3F800000 (1.0) -> out_data 0x00010000, flags 0, out_valid 9 edges after acceptance.
REQ-029 SHALL cover: 0xC0200000 (-2.5) -> out_data 0xFFFD8000, latency 8; out_ready held low 5 cycles -> out_data stable, in_ready=0 throughout.
REQ-030 SHALL cover the direct cases, each at latency 1:
- 0x47000000 (32768.0) -> 0x7FFFFFFF, out_ovf=1.
- 0xFF800000 (-inf) -> 0x80000000, out_ovf=1.
- 0x7FC00000 (NaN) -> 0, out_nan=1.
REQ-031 SHALL cover: 0x33800000 (2^-24) -> 0, latency 1, out_inexact=1 with the macro defined; 0x80000000 -> 0.
REQ-032 SHALL cover: rst pulsed 3 cycles after accepting 0x3F800000 -> out_valid stays 0 and in_ready=1 on the first edge after rst deasserts; the next operand 0x40000000 -> 0x00020000.
REQ-033 SHALL cover back-to-back traffic with in_valid held high: each result is delivered once, in order, and no operand is accepted on a DONE->IDLE edge.
